fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side adapter for the team's synchronous FIFOs. It issues `shift_out` pops into a FIFO with a configurable read latency and captures the returned words in a small credit-managed output buffer. It presents those words as a valid/ready stream with periodic `m_last` framing. It sits between any `shift_in`/`shift_out` FIFO and downstream stream consumers, and sustains one beat per cycle without a combinational path from `m_ready` to the FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `READ_LATENCY`, 1: cycles from a pop to valid data on `fifo_dout`. Legal values are 0 and 1.
- `BURST_LEN`, 8: beats per frame, must be ≥ 1. `m_last` marks the final beat of each frame.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  permits new pops. Words already in flight are still delivered.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_shift_out`  out  1  pop request to the FIFO.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  last beat of the frame.
- `busy`  out  1  a word is in flight or buffered.

## Operation
- **Buffer.** Circular buffer of `BUF_DEPTH = READ_LATENCY + 2` entries, with registered occupancy `occ`.
- **In-flight tracking.**
  - READ_LATENCY=1: the in-flight count `infl` is a 1-bit register set by a pop.
  - READ_LATENCY=0: `infl` is always 0.
- **Pop rule.** `fifo_shift_out = enable && !fifo_empty && (occ + infl < BUF_DEPTH)`.
  - Every term is registered or comes from a FIFO output.
  - `m_ready` never reaches `fifo_shift_out` combinationally.
  - `fifo_shift_out` is never asserted while `fifo_empty` is high, so the FIFO never underflows.
- **Capture.**
  - READ_LATENCY=0: `fifo_dout` is written into the buffer on the same edge as the pop.
  - READ_LATENCY=1: `fifo_dout` is written on the edge after the pop, when `infl` is 1.
- **Output.**
  - `m_data` is the buffer head and `m_valid = (occ != 0)`.
  - A handshake (`m_valid && m_ready`) retires the head.
  - A capture and a retire in the same cycle leave `occ` unchanged.
  - `m_data` and `m_valid` are stable while `m_valid && !m_ready`.
- **Framing.**
  - Beat counter `beat`, width `max(1,$clog2(BURST_LEN))`, increments on each handshake.
  - It wraps to 0 after `BURST_LEN-1`.
  - `m_last = m_valid && (beat == BURST_LEN-1)`.
  - With BURST_LEN=1, every valid beat carries `m_last`.
- **Status.** `busy = (occ != 0) || (infl != 0)`.
- **Disable.** Deasserting `enable` stops new pops only. Buffered and in-flight words drain normally, and `beat` is not reset.
- **Reset mid-operation.** Asserting reset discards buffered and in-flight words and clears `beat`. The FIFO's own pointers are not this block's concern.

## Timing
- Reset values:
  - `m_valid`, `m_last`, `fifo_shift_out` and `busy` are 0.
  - `m_data` is 0.
  - `occ`, `infl` and `beat` are 0.
- `fifo_shift_out` follows `fifo_empty` and `enable` combinationally, and is 0 during reset.
- Pop-to-valid latency, with the pop issued in cycle t:
  - READ_LATENCY=0: `m_valid` is high in cycle t+1.
  - READ_LATENCY=1: `m_valid` is high in cycle t+2.
- Throughput: with the FIFO non-empty and `m_ready` held high, one beat per cycle in steady state for both latencies.
- Backpressure: pops stop once `occ + infl` reaches `BUF_DEPTH`. The buffer never overflows, and no word is dropped or duplicated.
- The FIFO going empty mid-stream leaves gaps in `m_valid`. `beat` holds its value across those gaps.

## Configuration
- `FIFO_STREAM_READER_STATS_EN` defined:
  - Adds output `stat_beats` [31:0], which counts handshakes and wraps at 2^32.
  - Adds output `stat_stalls` [31:0], which counts cycles with `m_valid && !m_ready` and saturates at 0xFFFF_FFFF.
  - Both counters are cleared by reset.
- Macro undefined: neither port nor counter exists, and datapath behaviour is identical.

## Test plan
- **Streaming.** READ_LATENCY=1, FIFO preloaded with 0x00..0x0F, `m_ready`=1, `enable` rises at cycle 0.
  - First pop at cycle 0, `m_valid` at cycle 2.
  - 16 consecutive beats 0x00..0x0F.
  - `m_last` on 0x07 and 0x0F.
- **Backpressure.** READ_LATENCY=0, `m_ready` low for 10 cycles with the FIFO non-empty.
  - Exactly 2 pops, then `fifo_shift_out`=0.
  - `m_data` stable, and the stream order is preserved after release.
- **Underflow guard.** FIFO empty, `enable`=1, random `m_ready`.
  - `fifo_shift_out` never high.
  - `busy`=0 and `m_valid`=0.
- **Disable mid-stream.** READ_LATENCY=1, drop `enable` one cycle after a pop.
  - The in-flight word is delivered, then no further pops occur.
  - `beat` continues from its value when `enable` reasserts.
- **Reset mid-stream.** Assert `rst_n`=0 asynchronously while `occ`=2.
  - All outputs go to 0 immediately.
  - After release, the next delivered beat has `beat`=0 (an `m_last` gap of 7 beats).
- **Statistics** (`FIFO_STREAM_READER_STATS_EN`). 5 stall cycles, then 12 beats: `stat_stalls`=5 and `stat_beats`=12.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a shift_in/shift_out FIFO and re-presents the words as a framed valid/ready stream.
// Optional statistics counters are enabled by defining FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BURST_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_shift_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_stalls
`endif
);

  localparam int unsigned BUF_DEPTH = READ_LATENCY + 2;
  localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);
  localparam logic [1:0]        PTR_MAX  = 2'(BUF_DEPTH - 1);
  localparam logic [2:0]        DEPTH3   = 3'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [4];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  pop, capture, retire;

  always_comb begin
    // rst_n gates the pop so the FIFO is never shifted while this block is held in reset
    pop = rst_n && enable && !fifo_empty
          && (({1'b0, occ_q} + {2'b00, infl_q}) < DEPTH3);
    if (READ_LATENCY == 0) begin
      capture = pop;
    end else begin
      capture = infl_q;
    end
    infl_d  = (READ_LATENCY == 1) && pop;
    m_valid = (occ_q != 2'd0);
    retire  = m_valid && m_ready;

    occ_d = occ_q;
    if (capture && !retire) begin
      occ_d = occ_q + 2'd1;
    end else if (!capture && retire) begin
      occ_d = occ_q - 2'd1;
    end

    wr_ptr_d = wr_ptr_q;
    if (capture) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    rd_ptr_d = rd_ptr_q;
    if (retire) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? 2'd0 : rd_ptr_q + 2'd1;
    end

    beat_d = beat_q;
    if (retire) begin
      beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
    end

    fifo_shift_out = pop;
    m_data         = mem_q[rd_ptr_q];
    m_last         = m_valid && (beat_q == BEAT_MAX);
    busy           = m_valid || infl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= 1'b0;
      beat_q   <= '0;
    end else begin
      if (capture) begin
        mem_q[wr_ptr_q] <= fifo_dout;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      beat_q   <= beat_d;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] stat_beats_q, stat_stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (retire) begin
        stat_beats_q <= stat_beats_q + 32'd1;
      end
      if (m_valid && !m_ready && (stat_stalls_q != '1)) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_beats  = stat_beats_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: latency-1, latency-0 and single-beat-frame instances fed by behavioural FIFOs.
module tb_fifo_stream_reader;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  // latency-1 instance and its registered-output FIFO
  logic en1 = 1'b0, rdy1 = 1'b0;
  logic empty1, shift1, valid1, last1, busy1;
  logic [DW-1:0] dout1 = '0, data1;
  logic [DW-1:0] mem1 [256];
  logic [7:0] rd1 = '0, wr1 = '0;
  assign empty1 = (rd1 == wr1);

  // latency-0 instance and its show-ahead FIFO
  logic en0 = 1'b0, rdy0 = 1'b0;
  logic empty0, shift0, valid0, last0, busy0;
  logic [DW-1:0] dout0, data0;
  logic [DW-1:0] mem0 [256];
  logic [7:0] rd0 = '0, wr0 = '0;
  assign empty0 = (rd0 == wr0);
  assign dout0 = mem0[rd0];

  // single-beat-frame instance driven directly
  logic enb = 1'b0, rdyb = 1'b0, emptyb = 1'b1;
  logic shiftb, validb, lastb, busyb;
  logic [DW-1:0] doutb = '0, datab;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] sb1, ss1, sb0, ss0, sbb, ssb;
`endif

  always @(posedge clk) begin
    if (shift1) begin
      dout1 <= mem1[rd1];
      rd1 <= rd1 + 8'd1;
    end
    if (shift0) rd0 <= rd0 + 8'd1;
  end

  fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(1), .BURST_LEN(8)) u_rl1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_dout(dout1), .fifo_empty(empty1),
    .fifo_shift_out(shift1), .m_data(data1), .m_valid(valid1), .m_ready(rdy1),
    .m_last(last1), .busy(busy1)
`ifdef FIFO_STREAM_READER_STATS_EN
    , .stat_beats(sb1), .stat_stalls(ss1)
`endif
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(0), .BURST_LEN(8)) u_rl0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .fifo_dout(dout0), .fifo_empty(empty0),
    .fifo_shift_out(shift0), .m_data(data0), .m_valid(valid0), .m_ready(rdy0),
    .m_last(last0), .busy(busy0)
`ifdef FIFO_STREAM_READER_STATS_EN
    , .stat_beats(sb0), .stat_stalls(ss0)
`endif
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(0), .BURST_LEN(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .enable(enb), .fifo_dout(doutb), .fifo_empty(emptyb),
    .fifo_shift_out(shiftb), .m_data(datab), .m_valid(validb), .m_ready(rdyb),
    .m_last(lastb), .busy(busyb)
`ifdef FIFO_STREAM_READER_STATS_EN
    , .stat_beats(sbb), .stat_stalls(ssb)
`endif
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en1 = 1'b1; en0 = 1'b1; enb = 1'b1; emptyb = 1'b0;
    mem1[wr1] = 32'hAA; wr1 = wr1 + 8'd1;
    mem0[wr0] = 32'hBB; wr0 = wr0 + 8'd1;
    cyc(); settle();
    total++; if (shift1 !== 1'b0) begin bad++; $display("FAIL rst_shift1 got=%b exp=0", shift1); end
    total++; if (shift0 !== 1'b0) begin bad++; $display("FAIL rst_shift0 got=%b exp=0", shift0); end
    total++; if (shiftb !== 1'b0) begin bad++; $display("FAIL rst_shiftb got=%b exp=0", shiftb); end
    total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL rst_valid1 got=%b exp=0", valid1); end
    total++; if (last1 !== 1'b0) begin bad++; $display("FAIL rst_last1 got=%b exp=0", last1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy1 got=%b exp=0", busy1); end
    total++; if (data1 !== 32'h0) begin bad++; $display("FAIL rst_data1 got=%h exp=0", data1); end
    total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL rst_valid0 got=%b exp=0", valid0); end
    total++; if (data0 !== 32'h0) begin bad++; $display("FAIL rst_data0 got=%h exp=0", data0); end
    total++; if (lastb !== 1'b0) begin bad++; $display("FAIL rst_lastb got=%b exp=0", lastb); end
`ifdef FIFO_STREAM_READER_STATS_EN
    total++; if ((sb1 | ss1 | sb0 | ss0 | sbb | ssb) !== 32'h0) begin bad++; $display("FAIL rst_stats got=%h exp=0", sb1 | ss1 | sb0 | ss0 | sbb | ssb); end
`endif
    en1 = 1'b0; en0 = 1'b0; enb = 1'b0; emptyb = 1'b1;
    wr1 = rd1; wr0 = rd0;
    cyc(); rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_streaming();
    int nbeat = 0;
    for (int i = 0; i < 16; i++) begin mem1[wr1] = 32'(i); wr1 = wr1 + 8'd1; end
    rdy1 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      cyc();
      if (c == 0) en1 = 1'b1;
      settle();
      if (c == 0) begin total++; if (shift1 !== 1'b1) begin bad++; $display("FAIL stream_first_pop got=%b exp=1", shift1); end end
      if (c < 2) begin total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, valid1); end end
      if (valid1 && rdy1) begin
        total++; if (data1 !== 32'(nbeat)) begin bad++; $display("FAIL stream_data got=%h exp=%h", data1, 32'(nbeat)); end
        total++; if (last1 !== (nbeat == 7 || nbeat == 15)) begin bad++; $display("FAIL stream_last beat=%0d got=%b", nbeat, last1); end
        total++; if (c != nbeat + 2) begin bad++; $display("FAIL stream_cycle got=%0d exp=%0d", c, nbeat + 2); end
        nbeat++;
      end
    end
    total++; if (nbeat != 16) begin bad++; $display("FAIL stream_count got=%0d exp=16", nbeat); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL stream_busy_end got=%b exp=0", busy1); end
    cyc(); en1 = 1'b0;
  endtask

  task automatic test_backpressure();
    int pops = 0;
    int k = 0;
    for (int i = 0; i < 8; i++) begin mem0[wr0] = 32'h20 + 32'(i); wr0 = wr0 + 8'd1; end
    rdy0 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) en0 = 1'b1;
      settle();
      if (shift0) pops++;
      if (c >= 2) begin total++; if (shift0 !== 1'b0) begin bad++; $display("FAIL bp_shift c=%0d got=%b exp=0", c, shift0); end end
      if (c >= 1) begin
        total++; if (valid0 !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, valid0); end
        total++; if (data0 !== 32'h20) begin bad++; $display("FAIL bp_data_stable c=%0d got=%h exp=20", c, data0); end
      end
    end
    total++; if (pops != 2) begin bad++; $display("FAIL bp_pops got=%0d exp=2", pops); end
    for (int c = 0; c < 30 && k < 8; c++) begin
      cyc(); rdy0 = 1'b1; settle();
      if (valid0) begin
        total++; if (data0 !== 32'h20 + 32'(k)) begin bad++; $display("FAIL bp_order got=%h exp=%h", data0, 32'h20 + 32'(k)); end
        total++; if (last0 !== (k == 7)) begin bad++; $display("FAIL bp_last k=%0d got=%b", k, last0); end
        k++;
      end
    end
    total++; if (k != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", k); end
    cyc(); en0 = 1'b0;
  endtask

  task automatic test_underflow();
    for (int c = 0; c < 20; c++) begin
      cyc();
      en0 = 1'b1; en1 = 1'b1;
      rdy0 = 1'($urandom_range(0, 1)); rdy1 = 1'($urandom_range(0, 1));
      settle();
      total++; if (shift0 !== 1'b0 || shift1 !== 1'b0) begin bad++; $display("FAIL uf_shift got=%b%b exp=00", shift1, shift0); end
      total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL uf_busy got=%b%b exp=00", busy1, busy0); end
      total++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin bad++; $display("FAIL uf_valid got=%b%b exp=00", valid1, valid0); end
    end
    cyc(); en0 = 1'b0; en1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
  endtask

  task automatic test_disable();
    int k = 1;
    for (int i = 0; i < 9; i++) begin mem1[wr1] = 32'h40 + 32'(i); wr1 = wr1 + 8'd1; end
    cyc(); en1 = 1'b1; settle();
    total++; if (shift1 !== 1'b1) begin bad++; $display("FAIL dis_pop got=%b exp=1", shift1); end
    cyc(); en1 = 1'b0; settle();
    total++; if (shift1 !== 1'b0) begin bad++; $display("FAIL dis_nopop got=%b exp=0", shift1); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL dis_busy_inflight got=%b exp=1", busy1); end
    cyc(); settle();
    total++; if (valid1 !== 1'b1) begin bad++; $display("FAIL dis_valid got=%b exp=1", valid1); end
    total++; if (data1 !== 32'h40) begin bad++; $display("FAIL dis_data got=%h exp=40", data1); end
    total++; if (last1 !== 1'b0) begin bad++; $display("FAIL dis_last got=%b exp=0", last1); end
    for (int c = 0; c < 4; c++) begin
      cyc(); settle();
      total++; if (shift1 !== 1'b0 || valid1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL dis_idle got=%b%b%b exp=000", shift1, valid1, busy1); end
    end
    for (int c = 0; c < 30 && k < 9; c++) begin
      cyc(); en1 = 1'b1; settle();
      if (valid1) begin
        total++; if (data1 !== 32'h40 + 32'(k)) begin bad++; $display("FAIL dis_resume_data got=%h exp=%h", data1, 32'h40 + 32'(k)); end
        total++; if (last1 !== (k == 7)) begin bad++; $display("FAIL dis_resume_last k=%0d got=%b", k, last1); end
        k++;
      end
    end
    total++; if (k != 9) begin bad++; $display("FAIL dis_count got=%0d exp=9", k); end
    cyc(); en1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    for (int i = 0; i < 16; i++) begin mem1[wr1] = 32'h50 + 32'(i); wr1 = wr1 + 8'd1; end
    rdy1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(); en1 = 1'b1; settle();
    end
    total++; if (valid1 !== 1'b1 || data1 !== 32'h50) begin bad++; $display("FAIL rm_pre got=%b/%h exp=1/50", valid1, data1); end
    total++; if (shift1 !== 1'b0) begin bad++; $display("FAIL rm_pre_full got=%b exp=0", shift1); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", valid1); end
    total++; if (last1 !== 1'b0) begin bad++; $display("FAIL rm_last got=%b exp=0", last1); end
    total++; if (shift1 !== 1'b0) begin bad++; $display("FAIL rm_shift got=%b exp=0", shift1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy1); end
    total++; if (data1 !== 32'h0) begin bad++; $display("FAIL rm_data got=%h exp=0", data1); end
    cyc(); rst_n = 1'b1; rdy1 = 1'b1;
    for (int c = 0; c < 40 && k < 13; c++) begin
      cyc(); settle();
      if (valid1) begin
        total++; if (data1 !== 32'h53 + 32'(k)) begin bad++; $display("FAIL rm_data_after got=%h exp=%h", data1, 32'h53 + 32'(k)); end
        total++; if (last1 !== (k == 7)) begin bad++; $display("FAIL rm_last_after k=%0d got=%b", k, last1); end
        k++;
      end
    end
    total++; if (k != 13) begin bad++; $display("FAIL rm_count got=%0d exp=13", k); end
    cyc(); en1 = 1'b0;
  endtask

  task automatic test_burst1();
    for (int c = 0; c < 6; c++) begin
      cyc();
      enb = 1'b1; emptyb = 1'b0; rdyb = (c != 3); doutb = 32'h70 + 32'(c);
      settle();
      if (c == 0) begin total++; if (lastb !== 1'b0) begin bad++; $display("FAIL b1_last_idle got=%b exp=0", lastb); end end
      if (c >= 1) begin
        total++; if (validb !== 1'b1) begin bad++; $display("FAIL b1_valid c=%0d got=%b exp=1", c, validb); end
        total++; if (lastb !== 1'b1) begin bad++; $display("FAIL b1_last c=%0d got=%b exp=1", c, lastb); end
      end
    end
    cyc(); enb = 1'b0; emptyb = 1'b1; rdyb = 1'b1;
    cyc(); cyc(); cyc();
  endtask

`ifdef FIFO_STREAM_READER_STATS_EN
  task automatic test_stats();
    int k = 0;
    for (int i = 0; i < 12; i++) begin mem0[wr0] = 32'h60 + 32'(i); wr0 = wr0 + 8'd1; end
    rdy0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc(); en0 = 1'b1; settle();
    end
    for (int c = 0; c < 30 && k < 12; c++) begin
      cyc(); rdy0 = 1'b1; settle();
      if (valid0) begin
        total++; if (data0 !== 32'h60 + 32'(k)) begin bad++; $display("FAIL st_data got=%h exp=%h", data0, 32'h60 + 32'(k)); end
        k++;
      end
    end
    cyc(); en0 = 1'b0;
    cyc(); settle();
    total++; if (ss0 !== 32'd5) begin bad++; $display("FAIL st_stalls got=%0d exp=5", ss0); end
    total++; if (sb0 !== 32'd12) begin bad++; $display("FAIL st_beats got=%0d exp=12", sb0); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_underflow();
    test_disable();
    test_reset_mid();
    test_burst1();
`ifdef FIFO_STREAM_READER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
